uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter; the transmit-side counterpart of the Rx baud generator and sampler. Same frame format: 1 start, 8 data (LSB first), 1 parity, 2 stop = 12 bauds.
- Accepts bytes over a valid/ready handshake into a one-entry holding register. Serialises each byte onto the tx line with internal baud timing derived from ref_clk (500 MHz, 32768 bps).
- Back-to-back frames leave no idle gap on the line.

Parameters:
- CLKS_PER_BAUD, 15259, ref_clk cycles per bit (30518 ns / 2 ns); minimum 4.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity.
- STOP_BITS, 2, number of stop bits, 1 or 2.

Ports:
- ref_clk  input  1  single clock, 500 MHz.
- reset  input  1  one clock; reset is asynchronous and active-low (reset==0 resets).
- tx_data  input  8  byte to send; sampled on accept.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  holding register empty; combinational, equals !hold_full.
- tx  output  1  serial line, registered; idle high.
- busy  output  1  registered; high in any state other than IDLE.
- frame_done  output  1  registered one-cycle pulse at the end of the last stop bit.

Behaviour:
- Reset (asynchronous, while reset==0):
  - tx=1, busy=0, frame_done=0, hold_full=0 (so tx_ready=1).
  - State = IDLE; baud counter, bit counter and shift register cleared.
- Reset asserted mid-frame aborts the frame immediately and discards any held byte. No partial frame resumes after reset release.
- Accept: at any posedge where tx_valid && tx_ready, hold_reg <= tx_data and hold_full <= 1.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If hold_full: at the next edge, shift <= hold_reg, parity_bit <= (^hold_reg)^PARITY_ODD, hold_full <= 0, state -> START, tx <= 0, baud_cnt <= 0.
- Baud counter (16 bit) runs 0..CLKS_PER_BAUD-1 in every non-IDLE state. Each bit is held for exactly CLKS_PER_BAUD cycles. The bit advances on the edge where baud_cnt == CLKS_PER_BAUD-1.
- START -> DATA: tx <= shift[0].
- DATA:
  - Each bit end shifts right and increments bit_cnt (3 bit).
  - After bit 7, state -> PARITY, tx <= parity_bit.
- PARITY -> STOP: tx <= 1.
- STOP:
  - Lasts STOP_BITS baud periods.
  - At the end of the final stop period, frame_done <= 1 for one cycle.
  - If hold_full at that same edge, load immediately: state -> START, tx <= 0. No idle cycle is inserted.
  - Otherwise state -> IDLE.
- Latency:
  - Accept at edge N in IDLE gives the load at edge N+1; tx falls after edge N+1.
  - tx_ready returns high after edge N+1.
- Frame length: (10+STOP_BITS)*CLKS_PER_BAUD cycles, i.e. 12*CLKS_PER_BAUD for the defaults.
- Simultaneous events:
  - Accept and load never coincide, because accept requires hold_full==0.
  - Load at edge N clears hold_full, so a new byte can be accepted at edge N+1 at the earliest. The line can therefore be fully pipelined.
- tx_data changing while not accepted has no effect. A held byte is never overwritten.
- tx is glitch-free: it is driven only from a flop.

Test Plan:
- Reset: hold reset=0 mid-frame with CLKS_PER_BAUD=16 -> tx=1, busy=0, tx_ready=1 immediately. No frame_done pulse after release.
- Single byte 0xA5, even parity, CLKS_PER_BAUD=16:
  - Line sequence, each bit 16 cycles: 0, 1,0,1,0,0,1,0,1, parity 0, 1,1.
  - Total 192 cycles; frame_done pulses exactly once at cycle 192 after load.
- Parity: 0x07 -> parity bit 1 (even). Same byte with PARITY_ODD=1 -> parity bit 0. 0x00 even -> 0.
- Back-to-back: tx_valid held high with 0x55 then 0x3C.
  - Second byte accepted 1 cycle after first load; tx_ready stays low until the second load.
  - Stop bit of frame 1 is followed directly by the start bit of frame 2: 384 cycles total, no gap, 2 frame_done pulses.
- Full holding register: with a frame in flight and hold_full=1, present 0xFF with tx_valid=1 -> not accepted (tx_ready=0). The held byte is sent unchanged.
- STOP_BITS=1: byte 0x80 -> 11-baud frame (176 cycles at 16); line ends 1, parity 1, stop 1 (one stop bit).

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: 1 start, 8 data LSB first, parity, 1-2 stop bits.
// One-entry holding register; back-to-back frames leave no idle gap.
module uart_tx #(
   parameter int CLKS_PER_BAUD = 15259,
   parameter bit PARITY_ODD    = 1'b0,
   parameter int STOP_BITS     = 2
) (
   input  logic       ref_clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BAUD - 1);
   localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

   state_t      state_q, state_d;
   logic [15:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic        stop_cnt_q, stop_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        par_q, par_d;
   logic [7:0]  hold_q, hold_d;
   logic        hold_full_q, hold_full_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic        frame_done_q, frame_done_d;
   logic        bit_end;
   logic        load;

   assign tx_ready   = !hold_full_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

   always_comb begin
      state_d      = state_q;
      baud_cnt_d   = baud_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      stop_cnt_d   = stop_cnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      hold_d       = hold_q;
      hold_full_d  = hold_full_q;
      tx_d         = tx_q;
      frame_done_d = 1'b0;
      load         = 1'b0;
      bit_end      = (baud_cnt_q == BAUD_LAST);

      if (tx_valid && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end

      if (state_q != IDLE) begin
         baud_cnt_d = bit_end ? 16'd0 : baud_cnt_q + 16'd1;
      end

      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            load = hold_full_q;
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               bit_cnt_d = 3'd0;
               tx_d      = shift_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d   = {1'b0, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
                  tx_d    = par_q;
               end else begin
                  tx_d = shift_q[1];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d    = STOP;
               stop_cnt_d = 1'b0;
               tx_d       = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (stop_cnt_q == STOP_LAST) begin
                  frame_done_d = 1'b1;
                  // a waiting byte starts straight away, no idle bit
                  if (hold_full_q) begin
                     load = 1'b1;
                  end else begin
                     state_d = IDLE;
                     tx_d    = 1'b1;
                  end
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase

      if (load) begin
         shift_d     = hold_q;
         par_d       = (^hold_q) ^ PARITY_ODD;
         hold_full_d = 1'b0;
         state_d     = START;
         tx_d        = 1'b0;
         baud_cnt_d  = 16'd0;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge ref_clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         baud_cnt_q   <= 16'd0;
         bit_cnt_q    <= 3'd0;
         stop_cnt_q   <= 1'b0;
         shift_q      <= 8'd0;
         par_q        <= 1'b0;
         hold_q       <= 8'd0;
         hold_full_q  <= 1'b0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         baud_cnt_q   <= baud_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         stop_cnt_q   <= stop_cnt_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         hold_q       <= hold_d;
         hold_full_q  <= hold_full_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 16 clocks per baud: even/2 stop,
// odd/2 stop and even/1 stop instances.
module tb_uart_tx;

   logic       clk;
   logic       rst_n;
   logic [7:0] d0, d1, d2;
   logic       v0, v1, v2;
   logic       rdy0, rdy1, rdy2;
   logic       tx0, tx1, tx2;
   logic       busy0, busy1, busy2;
   logic       fd0, fd1, fd2;

   int checks;
   int errors;

   uart_tx #(.CLKS_PER_BAUD(16), .PARITY_ODD(1'b0), .STOP_BITS(2)) dut (
      .ref_clk(clk), .reset(rst_n), .tx_data(d0), .tx_valid(v0),
      .tx_ready(rdy0), .tx(tx0), .busy(busy0), .frame_done(fd0)
   );

   uart_tx #(.CLKS_PER_BAUD(16), .PARITY_ODD(1'b1), .STOP_BITS(2)) dut_odd (
      .ref_clk(clk), .reset(rst_n), .tx_data(d1), .tx_valid(v1),
      .tx_ready(rdy1), .tx(tx1), .busy(busy1), .frame_done(fd1)
   );

   uart_tx #(.CLKS_PER_BAUD(16), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut_s1 (
      .ref_clk(clk), .reset(rst_n), .tx_data(d2), .tx_valid(v2),
      .tx_ready(rdy2), .tx(tx2), .busy(busy2), .frame_done(fd2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++;
      if ({tx0, busy0, rdy0, fd0} !== 4'b1010) begin
         errors++;
         $display("FAIL reset0 got %b want 1010", {tx0, busy0, rdy0, fd0});
      end
      checks++;
      if ({tx1, busy1, rdy1, fd1} !== 4'b1010) begin
         errors++;
         $display("FAIL reset1 got %b want 1010", {tx1, busy1, rdy1, fd1});
      end
      checks++;
      if ({tx2, busy2, rdy2, fd2} !== 4'b1010) begin
         errors++;
         $display("FAIL reset2 got %b want 1010", {tx2, busy2, rdy2, fd2});
      end
      rst_n = 1'b1;
      repeat (2) tick();
   endtask

   // 0xA5 even: 0,1,0,1,0,0,1,0,1,p0,1,1 -> 12'hD4A (bit 0 first)
   task automatic test_single();
      logic [11:0] fr;
      int pulses;
      int bad;
      int bad_k;
      fr = 12'hD4A;
      pulses = 0;
      bad = 0;
      bad_k = -1;
      v0 = 1'b1;
      d0 = 8'hA5;
      tick();
      v0 = 1'b0;
      checks++;
      if (rdy0 !== 1'b0) begin
         errors++;
         $display("FAIL single_held rdy got %b want 0", rdy0);
      end
      checks++;
      if (tx0 !== 1'b1) begin
         errors++;
         $display("FAIL single_pre tx got %b want 1", tx0);
      end
      tick();
      checks++;
      if ({tx0, busy0, rdy0} !== 3'b011) begin
         errors++;
         $display("FAIL single_load got %b want 011", {tx0, busy0, rdy0});
      end
      for (int k = 0; k < 192; k++) begin
         if (k > 0) tick();
         if (fd0 === 1'b1) pulses++;
         if (tx0 !== fr[k/16]) begin
            bad++;
            if (bad_k < 0) bad_k = k;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL single_line bad %0d first at cycle %0d want bit %b",
                  bad, bad_k, fr[bad_k/16]);
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL single_early_done got %0d pulses want 0", pulses);
      end
      tick();
      checks++;
      if ({fd0, tx0, busy0} !== 3'b110) begin
         errors++;
         $display("FAIL single_end got %b want 110", {fd0, tx0, busy0});
      end
      tick();
      checks++;
      if (fd0 !== 1'b0) begin
         errors++;
         $display("FAIL single_pulse_len fd got %b want 0", fd0);
      end
   endtask

   task automatic test_parity();
      logic [7:0] bytes [2];
      logic       pe [2];
      logic       po [2];
      logic [11:0] fe;
      logic [11:0] fo;
      int bad;
      bytes[0] = 8'h07; pe[0] = 1'b1; po[0] = 1'b0;
      bytes[1] = 8'h00; pe[1] = 1'b0; po[1] = 1'b1;
      for (int p = 0; p < 2; p++) begin
         fe = {2'b11, pe[p], bytes[p], 1'b0};
         fo = {2'b11, po[p], bytes[p], 1'b0};
         bad = 0;
         v0 = 1'b1; v1 = 1'b1;
         d0 = bytes[p]; d1 = bytes[p];
         tick();
         v0 = 1'b0; v1 = 1'b0;
         tick();
         for (int k = 0; k < 192; k++) begin
            if (k > 0) tick();
            if (tx0 !== fe[k/16]) bad++;
            if (tx1 !== fo[k/16]) bad++;
            if (k == 152) begin
               checks++;
               if (tx0 !== pe[p]) begin
                  errors++;
                  $display("FAIL parity_even %h got %b want %b",
                           bytes[p], tx0, pe[p]);
               end
               checks++;
               if (tx1 !== po[p]) begin
                  errors++;
                  $display("FAIL parity_odd %h got %b want %b",
                           bytes[p], tx1, po[p]);
               end
            end
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL parity_line %h bad %0d want 0", bytes[p], bad);
         end
         tick();
         checks++;
         if ({fd0, fd1} !== 2'b11) begin
            errors++;
            $display("FAIL parity_done %h got %b want 11", bytes[p], {fd0, fd1});
         end
         repeat (2) tick();
      end
   endtask

   // 0x55 -> 12'hCAA, 0x3C -> 12'hC78, both even parity 0
   task automatic test_back_to_back();
      logic [11:0] f1;
      logic [11:0] f2;
      logic        e;
      int bad;
      int rdy_bad;
      int pulses;
      f1 = 12'hCAA;
      f2 = 12'hC78;
      bad = 0;
      rdy_bad = 0;
      pulses = 0;
      v0 = 1'b1;
      d0 = 8'h55;
      tick();
      d0 = 8'h3C;
      tick();
      checks++;
      if (rdy0 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_rdy_after_load got %b want 1", rdy0);
      end
      for (int k = 0; k <= 384; k++) begin
         if (k > 0) tick();
         if (k == 1) v0 = 1'b0;
         if (k >= 1 && k < 192 && rdy0 !== 1'b0) rdy_bad++;
         if (fd0 === 1'b1) pulses++;
         if (k < 384) begin
            e = (k < 192) ? f1[k/16] : f2[(k-192)/16];
            if (tx0 !== e) bad++;
         end
         if (k == 192) begin
            checks++;
            if ({fd0, tx0, busy0, rdy0} !== 4'b1011) begin
               errors++;
               $display("FAIL b2b_seam got %b want 1011",
                        {fd0, tx0, busy0, rdy0});
            end
         end
      end
      checks++;
      if (rdy_bad != 0) begin
         errors++;
         $display("FAIL b2b_rdy_low bad %0d want 0", rdy_bad);
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL b2b_line bad %0d want 0", bad);
      end
      checks++;
      if (pulses != 2 || fd0 !== 1'b1 || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done pulses %0d fd %b busy %b want 2 1 0",
                  pulses, fd0, busy0);
      end
      repeat (2) tick();
   endtask

   // 0x81 -> 12'hD02, 0x42 -> 12'hC84; 0xFF must never be taken
   task automatic test_hold_full();
      logic [11:0] f1;
      logic [11:0] f2;
      logic        e;
      int bad;
      f1 = 12'hD02;
      f2 = 12'hC84;
      bad = 0;
      v0 = 1'b1;
      d0 = 8'h81;
      tick();
      v0 = 1'b0;
      tick();
      v0 = 1'b1;
      d0 = 8'h42;
      for (int k = 0; k < 384; k++) begin
         if (k > 0) tick();
         if (k == 1) d0 = 8'hFF;
         if (k == 100) v0 = 1'b0;
         if (k == 50) begin
            checks++;
            if (rdy0 !== 1'b0) begin
               errors++;
               $display("FAIL hold_rdy got %b want 0", rdy0);
            end
         end
         e = (k < 192) ? f1[k/16] : f2[(k-192)/16];
         if (tx0 !== e) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL hold_line bad %0d want 0", bad);
      end
      tick();
      tick();
      checks++;
      if ({tx0, busy0, rdy0} !== 3'b101) begin
         errors++;
         $display("FAIL hold_idle got %b want 101", {tx0, busy0, rdy0});
      end
   endtask

   // 0x80, one stop bit: 0,0000000 1,p1,1 -> 11'h700
   task automatic test_one_stop();
      logic [10:0] fr;
      int bad;
      int pulses;
      fr = 11'h700;
      bad = 0;
      pulses = 0;
      v2 = 1'b1;
      d2 = 8'h80;
      tick();
      v2 = 1'b0;
      tick();
      for (int k = 0; k < 176; k++) begin
         if (k > 0) tick();
         if (fd2 === 1'b1) pulses++;
         if (tx2 !== fr[k/16]) bad++;
         if (k == 152) begin
            checks++;
            if (tx2 !== 1'b1) begin
               errors++;
               $display("FAIL stop1_parity got %b want 1", tx2);
            end
         end
      end
      checks++;
      if (bad != 0 || pulses != 0) begin
         errors++;
         $display("FAIL stop1_line bad %0d pulses %0d want 0 0", bad, pulses);
      end
      tick();
      checks++;
      if ({fd2, tx2, busy2} !== 3'b110) begin
         errors++;
         $display("FAIL stop1_end got %b want 110", {fd2, tx2, busy2});
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int bad;
      bad = 0;
      v0 = 1'b1;
      d0 = 8'hA5;
      tick();
      d0 = 8'h5A;
      tick();
      tick();
      v0 = 1'b0;
      repeat (50) tick();
      checks++;
      if ({busy0, rdy0} !== 2'b10) begin
         errors++;
         $display("FAIL rstmid_pre got %b want 10", {busy0, rdy0});
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({tx0, busy0, rdy0, fd0} !== 4'b1010) begin
         errors++;
         $display("FAIL rstmid_async got %b want 1010",
                  {tx0, busy0, rdy0, fd0});
      end
      tick();
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 250; k++) begin
         tick();
         if ({tx0, busy0, rdy0, fd0} !== 4'b1010) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rstmid_after bad %0d want 0", bad);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
      d0 = 8'h00; d1 = 8'h00; d2 = 8'h00;
      test_reset();
      test_single();
      test_parity();
      test_back_to_back();
      test_hold_full();
      test_one_stop();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
